// File: rtl/gomoku_pkg.sv
// rtl/gomoku_pkg.sv - shared types and board geometry for the board RAM arbiter
`timescale 1ns/1ps
package gomoku_pkg;

    localparam int BOARD_N = 15;
    localparam int CELLS   = BOARD_N * BOARD_N;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 2;
    localparam int STALL_W = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BLACK = 2'd1,
        WHITE = 2'd2
    } cell_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        VID  = 2'd1,
        GL   = 2'd2
    } owner_t;

endpackage

// File: rtl/board_clear_seq.sv
// rtl/board_clear_seq.sv - board clear sweep: address counter that only moves when granted
`timescale 1ns/1ps
module board_clear_seq #(
    parameter int ADDR_W = 8,
    parameter int CELLS  = 225
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              last
);

    assign last = (addr == ADDR_W'(CELLS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr <= '0;
            busy <= 1'b0;
        end else if (start && !busy) begin
            addr <= '0;
            busy <= 1'b1;
        end else if (busy && advance) begin
            if (last) begin
                addr <= '0;
                busy <= 1'b0;
            end else begin
                addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_mem_arbiter.sv
// rtl/board_mem_arbiter.sv - shares the board RAM: renderer > clear sweep > game logic
`timescale 1ns/1ps
module board_mem_arbiter
    import gomoku_pkg::*;
#(
    parameter int ADDR_W  = gomoku_pkg::ADDR_W,
    parameter int DATA_W  = gomoku_pkg::DATA_W,
    parameter int CELLS   = gomoku_pkg::CELLS,
    parameter int STALL_W = gomoku_pkg::STALL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               video_on,
    input  logic               vid_req,
    input  logic [ADDR_W-1:0]  vid_addr,
    output logic               vid_rvalid,
    output logic [DATA_W-1:0]  vid_rdata,
    input  logic               gl_req_valid,
    output logic               gl_req_ready,
    input  logic               gl_req_we,
    input  logic [ADDR_W-1:0]  gl_req_addr,
    input  logic [DATA_W-1:0]  gl_req_wdata,
    output logic               gl_rsp_valid,
    output logic [DATA_W-1:0]  gl_rsp_data,
    input  logic               clear_start,
    output logic               clear_busy,
    output logic [STALL_W-1:0] gl_stall_cnt,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata
);

    arb_state_t        state;
    owner_t            owner;
    logic [DATA_W-1:0] vid_hold;
    logic [DATA_W-1:0] gl_hold;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_last;
    logic              vid_gnt;
    logic              clr_gnt;
    logic              gl_in_range;

    board_clear_seq #(
        .ADDR_W (ADDR_W),
        .CELLS  (CELLS)
    ) u_clear_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (state == IDLE && clear_start),
        .advance (clr_gnt),
        .addr    (clr_addr),
        .busy    (clear_busy),
        .last    (clr_last)
    );

    // Nothing is granted in a reset cycle so the RAM is left untouched.
    always_comb begin
        vid_gnt      = rst_n && vid_req;
        clr_gnt      = rst_n && !vid_req && (state == CLEAR);
        gl_req_ready = rst_n && gl_req_valid && !vid_req && (state == IDLE);
        gl_in_range  = (gl_req_addr < ADDR_W'(CELLS));
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if (vid_gnt) begin
            mem_en   = 1'b1;
            mem_addr = vid_addr;
        end else if (clr_gnt) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = clr_addr;
            mem_wdata = DATA_W'(EMPTY);
        end else if (gl_req_ready && (!gl_req_we || gl_in_range)) begin
            mem_en    = 1'b1;
            mem_we    = gl_req_we;
            mem_addr  = gl_req_addr;
            mem_wdata = gl_req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner        <= NONE;
            vid_hold     <= '0;
            gl_hold      <= '0;
            gl_stall_cnt <= '0;
        end else begin
            case (state)
                IDLE:    if (clear_start) state <= CLEAR;
                CLEAR:   if (clr_gnt && clr_last) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (vid_gnt)
                owner <= VID;
            else if (gl_req_ready && !gl_req_we)
                owner <= GL;
            else
                owner <= NONE;
            if (owner == VID) vid_hold <= mem_rdata;
            if (owner == GL)  gl_hold  <= mem_rdata;
            if (gl_req_valid && !gl_req_ready && !(&gl_stall_cnt))
                gl_stall_cnt <= gl_stall_cnt + 1'b1;
        end
    end

    // The tag picks which port sees this cycle's read data; the other keeps its last value.
    assign vid_rvalid   = (owner == VID);
    assign gl_rsp_valid = (owner == GL);
    assign vid_rdata    = vid_rvalid   ? mem_rdata : vid_hold;
    assign gl_rsp_data  = gl_rsp_valid ? mem_rdata : gl_hold;

    // Outside the renderer window only the clear sweep can hold game logic off.
    assert property (@(posedge clk) disable iff (!rst_n)
        (gl_req_valid && !gl_req_ready && !video_on && !vid_req) |-> (state == CLEAR));

endmodule

// File: tb/tb_board_mem_arbiter.sv
// tb/tb_board_mem_arbiter.sv - randomized scoreboard bench for board_mem_arbiter
`timescale 1ns/1ps
module tb_board_mem_arbiter;

    localparam int CELLS = 225;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        video_on = 1'b0;
    logic        vid_req = 1'b0;
    logic [7:0]  vid_addr = '0;
    logic        vid_rvalid;
    logic [1:0]  vid_rdata;
    logic        gl_req_valid = 1'b0;
    logic        gl_req_ready;
    logic        gl_req_we = 1'b0;
    logic [7:0]  gl_req_addr = '0;
    logic [1:0]  gl_req_wdata = '0;
    logic        gl_rsp_valid;
    logic [1:0]  gl_rsp_data;
    logic        clear_start = 1'b0;
    logic        clear_busy;
    logic [15:0] gl_stall_cnt;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [1:0]  mem_wdata;
    logic [1:0]  mem_rdata;

    always #5 clk = ~clk;

    board_mem_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .video_on     (video_on),
        .vid_req      (vid_req),
        .vid_addr     (vid_addr),
        .vid_rvalid   (vid_rvalid),
        .vid_rdata    (vid_rdata),
        .gl_req_valid (gl_req_valid),
        .gl_req_ready (gl_req_ready),
        .gl_req_we    (gl_req_we),
        .gl_req_addr  (gl_req_addr),
        .gl_req_wdata (gl_req_wdata),
        .gl_rsp_valid (gl_rsp_valid),
        .gl_rsp_data  (gl_rsp_data),
        .clear_start  (clear_start),
        .clear_busy   (clear_busy),
        .gl_stall_cnt (gl_stall_cnt),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Board RAM: single port, synchronous read.
    logic [1:0] ram [256];
    logic       ram_ready = 1'b0;

    function automatic logic [1:0] init_val(input int i);
        return 2'((i * 5 + i / 7) % 4);
    endfunction

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
            ram_ready <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state.
    logic [1:0] ref_mem [256];
    logic [1:0] vid_q [$];
    logic [1:0] gl_q [$];
    bit         m_clear = 1'b0;
    int         m_caddr = 0;
    int         m_stall = 0;
    bit         gl_pend = 1'b0;
    bit         g_we = 1'b0;
    logic [7:0] g_addr = '0;
    logic [1:0] g_wd = '0;
    int         last_busy = 0;

    // Monitor: pops expected read data whenever a response port fires.
    logic [1:0] last_vid = '0;
    logic [1:0] last_gl = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                if (vid_rvalid && vid_q.size() > 0) chk("vid_rdata", vid_rdata, vid_q.pop_front());
                if (gl_rsp_valid && gl_q.size() > 0) chk("gl_rsp_data", gl_rsp_data, gl_q.pop_front());
                last_vid = '0;
                last_gl  = '0;
            end else begin
                if (vid_rvalid) begin
                    if (vid_q.size() == 0) chk("vid_unexpected_rvalid", 1, 0);
                    else begin
                        last_vid = vid_q.pop_front();
                        chk("vid_rdata", vid_rdata, last_vid);
                    end
                end else chk("vid_rdata_hold", vid_rdata, last_vid);
                if (gl_rsp_valid) begin
                    if (gl_q.size() == 0) chk("gl_unexpected_rsp", 1, 0);
                    else begin
                        last_gl = gl_q.pop_front();
                        chk("gl_rsp_data", gl_rsp_data, last_gl);
                    end
                end else chk("gl_rsp_hold", gl_rsp_data, last_gl);
            end
        end
    end

    // One clock of stimulus; entered and left at posedge+1.
    task automatic step(input bit v, input logic [7:0] va, input bit cs);
        bit e_rdy;
        bit e_we;
        bit was_clear;
        vid_req      = v;
        vid_addr     = va;
        video_on     = 1'($urandom_range(0, 1));
        clear_start  = cs;
        gl_req_valid = gl_pend;
        gl_req_we    = g_we;
        gl_req_addr  = g_addr;
        gl_req_wdata = g_wd;
        #2;
        was_clear = m_clear;
        e_rdy = gl_pend && !v && !m_clear;
        e_we  = !v && (m_clear || (e_rdy && g_we && g_addr < CELLS));
        chk("gl_req_ready", gl_req_ready, e_rdy);
        chk("mem_we", mem_we, e_we);
        chk("clear_busy", clear_busy, m_clear);
        chk("gl_stall_cnt", gl_stall_cnt, m_stall);
        last_busy = clear_busy;
        if (v) chk("mem_addr_vid", mem_addr, va);
        else if (m_clear) chk("mem_addr_clear", mem_addr, m_caddr);
        if (v) vid_q.push_back(ref_mem[va]);
        else if (m_clear) begin
            ref_mem[m_caddr] = 2'd0;
            if (m_caddr == CELLS - 1) begin
                m_clear = 1'b0;
                m_caddr = 0;
            end else m_caddr++;
        end else if (e_rdy) begin
            if (g_we && g_addr < CELLS) ref_mem[g_addr] = g_wd;
            if (!g_we) gl_q.push_back(ref_mem[g_addr]);
        end
        if (e_rdy) gl_pend = 1'b0;
        else if (gl_pend && m_stall < 65535) m_stall++;
        if (cs && !was_clear) begin
            m_clear = 1'b1;
            m_caddr = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_n        = 1'b0;
        vid_req      = 1'b0;
        gl_req_valid = 1'b0;
        clear_start  = 1'b0;
        gl_pend      = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_clear = 1'b0;
        m_caddr = 0;
        m_stall = 0;
        chk("rst_vid_rvalid", vid_rvalid, 0);
        chk("rst_gl_rsp_valid", gl_rsp_valid, 0);
        chk("rst_vid_rdata", vid_rdata, 0);
        chk("rst_gl_rsp_data", gl_rsp_data, 0);
        chk("rst_clear_busy", clear_busy, 0);
        chk("rst_stall_cnt", gl_stall_cnt, 0);
        chk("rst_gl_req_ready", gl_req_ready, 0);
        chk("rst_mem_en", mem_en, 0);
    endtask

    task automatic gl_issue(input bit we, input logic [7:0] addr, input logic [1:0] wd);
        gl_pend = 1'b1;
        g_we    = we;
        g_addr  = addr;
        g_wd    = wd;
        for (int i = 0; i < 1000 && gl_pend; i++) step(1'b0, 8'd0, 1'b0);
        if (gl_pend) begin
            chk("gl_issue_timeout", 1, 0);
            gl_pend = 1'b0;
        end
    endtask

    task automatic run_clear(input bit steal, input int exp_len);
        int cnt;
        cnt = 0;
        step(1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 2000 && m_clear; i++) begin
            step(steal && (i % 2 == 0), 8'($urandom_range(0, 255)), 1'b0);
            cnt += last_busy;
        end
        chk("clear_busy_len", cnt, exp_len);
    endtask

    task automatic sweep_read();
        for (int a = 0; a < 256; a++) step(1'b1, 8'(a), 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        do_reset(2);

        step(1'b1, 8'd37, 1'b0);
        step(1'b0, 8'd0, 1'b0);

        gl_issue(1'b1, 8'd112, 2'd2);
        gl_issue(1'b0, 8'd112, 2'd0);
        step(1'b0, 8'd0, 1'b0);

        gl_pend = 1'b1;
        g_we    = 1'b0;
        g_addr  = 8'd112;
        for (int i = 0; i < 5; i++) step(1'b1, 8'(10 + i), 1'b0);
        chk("stall_after_5", gl_stall_cnt, 5);
        step(1'b0, 8'd0, 1'b0);
        chk("gl_accept_6th", gl_pend, 0);

        gl_issue(1'b1, 8'd230, 2'd3);
        step(1'b1, 8'd230, 1'b0);

        run_clear(1'b0, 225);
        gl_pend = 1'b1;
        g_we    = 1'b1;
        g_addr  = 8'd5;
        g_wd    = 2'd1;
        run_clear(1'b1, 450);
        step(1'b0, 8'd0, 1'b0);
        sweep_read();

        for (int n = 0; n < 1500; n++) begin
            if (!gl_pend && $urandom_range(0, 1) == 1) begin
                gl_pend = 1'b1;
                g_we    = 1'($urandom_range(0, 1));
                g_addr  = 8'($urandom_range(0, 239));
                g_wd    = 2'($urandom_range(0, 3));
            end
            step($urandom_range(0, 2) == 0, 8'($urandom_range(0, 255)), $urandom_range(0, 299) == 0);
        end
        for (int i = 0; i < 2000 && (gl_pend || m_clear); i++) step(1'b0, 8'd0, 1'b0);

        step(1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 500 && m_caddr != 100; i++) step(1'b0, 8'd0, 1'b0);
        chk("reached_clear_addr_100", m_caddr, 100);
        do_reset(1);
        step(1'b0, 8'd0, 1'b1);
        chk("restart_addr0", mem_addr, 0);
        for (int i = 0; i < 500 && m_clear; i++) step(1'b0, 8'd0, 1'b0);
        sweep_read();

        repeat (3) step(1'b0, 8'd0, 1'b0);
        chk("vid_q_drained", vid_q.size(), 0);
        chk("gl_q_drained", gl_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/board_mem_arbiter.md
Name: board_mem_arbiter

Overview:
Shares the single-port, synchronous-read board-state RAM (one cell per entry) between three requesters: the pixel renderer, the game-logic engine and an internal board-clear sequencer. Renderer reads are never stalled, so on-screen data is deterministic. Game logic uses a valid/ready handshake and is served in free cycles. Sits between the VGA timing/renderer path and the board RAM, clocked on the pixel clock.

Parameters:
ADDR_W, 8, board RAM address width
DATA_W, 2, cell width (0 empty, 1 black, 2 white, 3 reserved)
CELLS, 225, number of valid cells (15x15); addresses 0..CELLS-1
STALL_W, 16, width of game-logic stall counter

Ports:
clk  in  1  pixel clock
rst_n  in  1  synchronous active-low reset
video_on  in  1  active-display window from the sync generator
vid_req  in  1  renderer read request (no handshake, always granted)
vid_addr  in  ADDR_W  renderer read address
vid_rvalid  out  1  renderer read data valid
vid_rdata  out  DATA_W  renderer read data
gl_req_valid  in  1  game-logic request valid
gl_req_ready  out  1  game-logic request accepted this cycle
gl_req_we  in  1  1 = write, 0 = read
gl_req_addr  in  ADDR_W  game-logic address
gl_req_wdata  in  DATA_W  game-logic write data
gl_rsp_valid  out  1  game-logic read data valid
gl_rsp_data  out  DATA_W  game-logic read data
clear_start  in  1  pulse: zero the whole board
clear_busy  out  1  clear sweep in progress
gl_stall_cnt  out  STALL_W  saturating count of cycles with gl_req_valid=1 and gl_req_ready=0
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en with mem_we=0

Behaviour:
- Reset (rst_n=0 at clk edge): FSM to IDLE; clear address 0; vid_rvalid, gl_rsp_valid, gl_req_ready, clear_busy, mem_en, mem_we = 0; vid_rdata, gl_rsp_data = 0; gl_stall_cnt = 0; read-owner tag = NONE. Reset mid-clear abandons the sweep; RAM contents are undefined and a new clear_start is required.
- FSM states: IDLE, CLEAR. IDLE->CLEAR on clear_start. CLEAR->IDLE in the cycle after the write to address CELLS-1 is issued. clear_start while in CLEAR is ignored.
- Fixed priority per cycle: renderer (vid_req=1, any video_on) > clear sweep > game logic.
- Grant is combinational from current inputs and state. mem_* are driven combinationally from the granted requester; no port sees an idle bubble.
- Renderer: on vid_req, mem_en=1, mem_we=0, mem_addr=vid_addr. Exactly 1 cycle later: vid_rvalid=1 and vid_rdata=mem_rdata.
- Clear: on each cycle granted, write 0 to clear address, then increment. Cycles stolen by the renderer pause the sweep without skipping addresses. clear_busy=1 from the cycle after clear_start through the last write.
- Game logic: gl_req_ready = gl_req_valid & ~vid_req & (state==IDLE). On a game-logic read: gl_rsp_valid=1 one cycle later, gl_rsp_data=mem_rdata. Writes produce no response. Requester must hold request fields stable until ready.
- Out-of-range address (>= CELLS): reads are performed normally. Game-logic writes are accepted (ready=1) but mem_we is suppressed.
- Read-owner tag (NONE/VID/GL), registered each cycle, steers mem_rdata to exactly one response port. Non-owner rdata outputs hold their last value.
- Stall counter: +1 each cycle with gl_req_valid & ~gl_req_ready; saturates at all-ones; never clears except on reset.
- video_on is used only for stall accounting. Stall cycles with video_on=0 and vid_req=0 can only come from CLEAR.

Decomposition:
- Package gomoku_pkg: cell_t enum (EMPTY, BLACK, WHITE), BOARD_N=15, CELLS, ADDR_W, arb_state_t (IDLE, CLEAR), owner_t (NONE, VID, GL).
- One natural sub-module: board_clear_seq (address counter, busy flag, advance-on-grant input).

Test Plan:
- Reset, then vid_req=1 with vid_addr=37 for one cycle -> next cycle vid_rvalid=1, vid_rdata = RAM[37]; gl_rsp_valid stays 0.
- gl write addr 112 data 2 with vid_req=0 -> ready=1 same cycle, mem_we=1; later gl read 112 -> gl_rsp_valid after 1 cycle with data 2.
- gl_req_valid held while vid_req=1 for 5 cycles -> ready=0 for those 5 cycles, gl_stall_cnt=5, ready=1 on the 6th cycle.
- clear_start with no renderer traffic -> clear_busy high 225 cycles, addresses 0..224 written with 0, then IDLE. With renderer stealing every other cycle -> 450 cycles, no address skipped.
- gl write to addr 230 -> ready=1, mem_we=0, RAM unchanged. gl_req_valid during CLEAR -> ready=0 until clear_busy falls.
- rst_n low at clear address 100 -> all outputs zero next cycle, state IDLE. Fresh clear_start restarts the sweep at address 0.
